// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared states and constants for the instruction-memory loader.
package program_loader_pkg;
    localparam int PL_DEPTH   = 16;
    localparam int PL_ADDR_W  = 4;
    localparam int PL_INSTR_W = 9;
    localparam logic [7:0] PL_HI_RSVD_MASK = 8'hFE;
    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_LO, S_HI, S_CSUM, S_DONE, S_ERR
    } loader_state_t;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: host byte stream plus instruction-memory write port.
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int ADDR_W  = PL_ADDR_W,
    parameter int INSTR_W = PL_INSTR_W
) ();
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               im_we;
    logic [ADDR_W-1:0]  im_waddr;
    logic [INSTR_W-1:0] im_wdata;
    modport master (output rx_data, rx_valid, input rx_ready, im_we, im_waddr, im_wdata);
    modport slave  (input rx_data, rx_valid, output rx_ready, im_we, im_waddr, im_wdata);
endinterface

// File: rtl/program_loader.sv
// program_loader: receives a framed program byte stream and writes it into instruction memory.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DEPTH   = PL_DEPTH,
    parameter int ADDR_W  = PL_ADDR_W,
    parameter int INSTR_W = PL_INSTR_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    program_loader_if.slave bus,
    output logic cpu_hold,
    output logic done,
    output logic err
);
    loader_state_t st, nxt;
    logic [ADDR_W-1:0] addr, last;
    logic [7:0] lo, csum;
    logic xfer, start_ok, hi_bad, n_bad;

    assign xfer     = bus.rx_valid && bus.rx_ready;
    assign start_ok = start && (st == S_IDLE || st == S_DONE || st == S_ERR);
    assign hi_bad   = |(bus.rx_data & PL_HI_RSVD_MASK);
    assign n_bad    = bus.rx_data == 8'd0 || {24'd0, bus.rx_data} > 32'(DEPTH);
    assign bus.rx_ready = st == S_COUNT || st == S_LO || st == S_HI || st == S_CSUM;
    assign cpu_hold = bus.rx_ready || st == S_ERR;
    assign done     = st == S_DONE;
    assign err      = st == S_ERR;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) st <= S_IDLE;
        else        st <= nxt;

    always_comb begin
        nxt = st;
        case (st)
            S_IDLE, S_DONE, S_ERR: nxt = start_ok ? S_COUNT : st;
            S_COUNT: nxt = xfer ? (n_bad ? S_ERR : S_LO) : st;
            S_LO:    nxt = xfer ? S_HI : st;
            S_HI:    nxt = xfer ? (hi_bad ? S_ERR : (addr == last ? S_CSUM : S_LO)) : st;
            S_CSUM:  nxt = xfer ? (bus.rx_data == csum ? S_DONE : S_ERR) : st;
            default: nxt = S_IDLE;
        endcase
    end

    // The checksum byte itself is compared, never folded into the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr         <= '0;
            last         <= '0;
            lo           <= '0;
            csum         <= '0;
            bus.im_we    <= 1'b0;
            bus.im_waddr <= '0;
            bus.im_wdata <= '0;
        end else begin
            bus.im_we <= 1'b0;
            if (start_ok) begin
                addr <= '0;
                csum <= '0;
            end
            if (xfer && st != S_CSUM) csum <= csum ^ bus.rx_data;
            if (xfer && st == S_COUNT) last <= ADDR_W'(bus.rx_data - 8'd1);
            if (xfer && st == S_LO) lo <= bus.rx_data;
            if (xfer && st == S_HI && !hi_bad) begin
                bus.im_we    <= 1'b1;
                bus.im_waddr <= addr;
                bus.im_wdata <= INSTR_W'({bus.rx_data[0], lo});
                if (addr != last) addr <= addr + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frame vectors plus multi-cycle corner sequences for program_loader.
module tb_program_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, done, err;
    int checks = 0;
    int errors = 0;
    logic [3:0] wa_q[$];
    logic [8:0] wd_q[$];

    program_loader_if #(.ADDR_W(4), .INSTR_W(9)) bus ();

    program_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.slave),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.im_we) begin
            wa_q.push_back(bus.im_waddr);
            wd_q.push_back(bus.im_wdata);
        end

    typedef struct packed {
        logic [3:0]  len;
        logic [63:0] frame;
        logic [1:0]  nw;
        logic [26:0] wr;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        logic acc;
        bus.rx_valid = 1'b0;
        repeat (gap) cycle();
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            acc = bus.rx_ready;
            cycle();
        end
        if (!acc) chk("accept_timeout", 0, 1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic start_load();
        wa_q.delete();
        wd_q.delete();
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("start_ready", bus.rx_ready, 1);
        chk("start_hold", cpu_hold, 1);
        chk("start_done_clr", done, 0);
        chk("start_err_clr", err, 0);
    endtask

    task automatic check_writes(input string tag, input int nw, input logic [26:0] wr);
        chk({tag, "_nwrites"}, wa_q.size(), nw);
        for (int i = 0; i < nw && i < wa_q.size(); i++) begin
            chk({tag, "_waddr"}, wa_q[i], i);
            chk({tag, "_wdata"}, wd_q[i], wr[26-9*i -: 9]);
        end
    endtask

    initial begin
        logic [7:0] cs, lo_b, hi_b;
        // checksum of 03,12,00,34,01,56,00 is 0x72
        vecs[0] = '{len: 8, frame: 64'h03_12_00_34_01_56_00_72, nw: 3,
                    wr: {9'h012, 9'h134, 9'h056}, done: 1, err: 0};
        vecs[1] = '{len: 1, frame: 64'h00_00_00_00_00_00_00_00, nw: 0, wr: 0, done: 0, err: 1};
        vecs[2] = '{len: 3, frame: 64'h01_AA_02_00_00_00_00_00, nw: 0, wr: 0, done: 0, err: 1};
        vecs[3] = '{len: 4, frame: 64'h01_AA_01_AA_00_00_00_00, nw: 1,
                    wr: {9'h1AA, 18'h0}, done: 1, err: 0};
        vecs[4] = '{len: 4, frame: 64'h01_AA_01_00_00_00_00_00, nw: 1,
                    wr: {9'h1AA, 18'h0}, done: 0, err: 1};
        vecs[5] = '{len: 1, frame: 64'h11_00_00_00_00_00_00_00, nw: 0, wr: 0, done: 0, err: 1};
        vecs[6] = '{len: 6, frame: 64'h02_FF_01_00_00_FC_00_00, nw: 2,
                    wr: {9'h1FF, 9'h000, 9'h0}, done: 1, err: 0};
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        #1;
        chk("rst_ready", bus.rx_ready, 0);
        chk("rst_we", bus.im_we, 0);
        chk("rst_waddr", bus.im_waddr, 0);
        chk("rst_wdata", bus.im_wdata, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        for (int v = 0; v < 7; v++) begin
            start_load();
            for (int i = 0; i < vecs[v].len; i++) send(vecs[v].frame[63-8*i -: 8], 0);
            chk($sformatf("v%0d_done", v), done, vecs[v].done);
            chk($sformatf("v%0d_err", v), err, vecs[v].err);
            chk($sformatf("v%0d_hold", v), cpu_hold, vecs[v].err);
            chk($sformatf("v%0d_ready", v), bus.rx_ready, 0);
            cycle();
            chk($sformatf("v%0d_we_idle", v), bus.im_we, 0);
            chk($sformatf("v%0d_done_lvl", v), done, vecs[v].done);
            check_writes($sformatf("v%0d", v), vecs[v].nw, vecs[v].wr);
        end

        // Full depth with random gaps and ignored start pulses
        start_load();
        cs = 8'h10;
        send(8'h10, $urandom_range(0, 2));
        for (int i = 0; i < 16; i++) begin
            lo_b = 8'(i * 37 + 5);
            hi_b = {7'd0, 1'(i)};
            cs   = cs ^ lo_b ^ hi_b;
            if (i == 5) begin
                start = 1'b1;
                cycle();
                start = 1'b0;
                chk("mid_start_ready", bus.rx_ready, 1);
            end
            send(lo_b, $urandom_range(0, 3));
            if (i == 9) start = 1'b1;
            send(hi_b, i == 9 ? 0 : $urandom_range(0, 3));
            start = 1'b0;
        end
        chk("full_not_done", done, 0);
        send(cs, 1);
        chk("full_done", done, 1);
        chk("full_hold", cpu_hold, 0);
        chk("full_err", err, 0);
        cycle();
        chk("full_nwrites", wa_q.size(), 16);
        for (int i = 0; i < 16 && i < wa_q.size(); i++) begin
            chk("full_waddr", wa_q[i], i);
            chk("full_wdata", wd_q[i], {1'(i), 8'(i * 37 + 5)});
        end

        // Reset while the second write is pending
        start_load();
        send(8'h03, 0);
        send(8'h12, 0);
        send(8'h00, 0);
        send(8'h34, 0);
        send(8'h01, 0);
        chk("pend_we", bus.im_we, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", bus.im_we, 0);
        chk("mid_rst_waddr", bus.im_waddr, 0);
        chk("mid_rst_wdata", bus.im_wdata, 0);
        chk("mid_rst_ready", bus.rx_ready, 0);
        chk("mid_rst_hold", cpu_hold, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("mid_rst_nwrites", wa_q.size(), 1);
        start_load();
        for (int i = 0; i < 8; i++) send(vecs[0].frame[63-8*i -: 8], 0);
        chk("reload_done", done, 1);
        cycle();
        check_writes("reload", 3, vecs[0].wr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
